// File: rtl/fifo_uart_tx.sv
// Pops bytes from the read side of a byte FIFO and serialises each as a UART frame.
// Optional even parity bit is enabled by defining FIFO_UART_TX_PARITY_EN.
//
// state  | meaning
// IDLE   | line high, waiting for a non-empty FIFO
// REQ    | one-cycle fifo_ren pulse
// WAIT   | fifo_dout becomes valid, captured at end of cycle
// START  | start bit (low)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (parity build only)
// STOP   | STOP_BITS stop bits (high), tx_done on the final cycle
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_ren,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_DATA  = 3'd4,
`ifdef FIFO_UART_TX_PARITY_EN
    S_PARITY = 3'd5,
`endif
    S_STOP  = 3'd6
  } state_t;

  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_n;
  logic          stop_idx, stop_n;
  logic [7:0]    data, data_n;
  logic          tx_n, ren_n, busy_n, done_n;
  logic          baud_end;

  assign baud_end = (baud == BAUD_MAX);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= S_IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      data     <= '0;
      tx       <= 1'b1;
      fifo_ren <= 1'b0;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      baud     <= baud_n;
      bit_idx  <= bit_n;
      stop_idx <= stop_n;
      data     <= data_n;
      tx       <= tx_n;
      fifo_ren <= ren_n;
      busy     <= busy_n;
      tx_done  <= done_n;
    end
  end

  // Outputs are registered from the next-state values so they align with the state they describe.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    stop_n  = stop_idx;
    data_n  = data;
    case (state)
      S_IDLE: if (!fifo_empty) state_n = S_REQ;
      S_REQ:  state_n = S_WAIT;
      S_WAIT: begin
        data_n  = fifo_dout;
        baud_n  = '0;
        bit_n   = '0;
        stop_n  = 1'b0;
        state_n = S_START;
      end
      S_START: begin
        baud_n = baud_end ? '0 : baud + BW'(1);
        if (baud_end) state_n = S_DATA;
      end
      S_DATA: begin
        baud_n = baud_end ? '0 : baud + BW'(1);
        if (baud_end) begin
          if (bit_idx == 3'd7) begin
            bit_n = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: begin
        baud_n = baud_end ? '0 : baud + BW'(1);
        if (baud_end) state_n = S_STOP;
      end
`endif
      S_STOP: begin
        baud_n = baud_end ? '0 : baud + BW'(1);
        if (baud_end) begin
          if (stop_idx == STOP_LAST) begin
            stop_n  = 1'b0;
            state_n = S_IDLE;
          end else begin
            stop_n = stop_idx + 1'b1;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        baud_n  = '0;
        bit_n   = '0;
        stop_n  = 1'b0;
      end
    endcase

    tx_n = 1'b1;
    case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = data_n[bit_n];
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: tx_n = ^data_n;
`endif
      default:  tx_n = 1'b1;
    endcase
    ren_n  = (state_n == S_REQ);
    busy_n = (state_n != S_IDLE);
    done_n = (state_n == S_STOP) && (baud_n == BAUD_MAX) && (stop_n == STOP_LAST);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two DUTs (1 and 2 stop bits) fed by behavioural FIFOs,
// frames decoded against a scoreboard of expected bytes, parity and frame lengths.
module tb_fifo_uart_tx;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_;
  logic       empty1 = 1'b1, empty2 = 1'b1;
  logic [7:0] dout1 = 8'h00, dout2 = 8'h00;
  logic       ren1, ren2, tx1, tx2, busy1, busy2, done1, done2;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_(rst_), .fifo_empty(empty1), .fifo_dout(dout1),
    .fifo_ren(ren1), .tx(tx1), .busy(busy1), .tx_done(done1));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_(rst_), .fifo_empty(empty2), .fifo_dout(dout2),
    .fifo_ren(ren2), .tx(tx2), .busy(busy2), .tx_done(done2));

  logic       sel = 1'b0;
  logic       tx_m, busy_m, done_m;
  assign tx_m   = sel ? tx2   : tx1;
  assign busy_m = sel ? busy2 : busy1;
  assign done_m = sel ? done2 : done1;

  logic [7:0] fq1[$];
  logic [7:0] fq2[$];
  int ren_cnt1 = 0, ren_cnt2 = 0;

  always @(posedge clk) begin
    if (ren1 && fq1.size() > 0) dout1 <= fq1.pop_front();
    if (ren2 && fq2.size() > 0) dout2 <= fq2.pop_front();
  end

  always @(negedge clk) begin
    empty1 <= (fq1.size() == 0);
    empty2 <= (fq2.size() == 0);
    if (ren1) ren_cnt1++;
    if (ren2) ren_cnt2++;
  end

  typedef struct {
    logic       sel;
    logic [7:0] din;
    logic       par;
    int         len;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[7];
  int total = 0, bad = 0;

  task automatic check_val(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input vec_t v);
    @(posedge clk);
    #2;
    if (v.sel) fq2.push_back(v.din);
    else       fq1.push_back(v.din);
    sb.push_back(v);
  endtask

  task automatic check_frame();
    vec_t e;
    int   t, nerr, done_at, done_cnt, busy_low, sym;
    logic exp_b;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_underflow: got 0 entries expected >=1");
      return;
    end
    e = sb.pop_front();
    sel = e.sel;
    t = 0;
    while (tx_m !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (tx_m !== 1'b0) begin
      total++; bad++;
      $display("FAIL frame_start_timeout: got no start bit expected one for byte %02h", e.din);
      return;
    end
    nerr = 0; done_at = -1; done_cnt = 0; busy_low = 0;
    for (int i = 0; i < e.len; i++) begin
      sym = i / CPB;
      if (sym == 0)                 exp_b = 1'b0;
      else if (sym <= 8)            exp_b = e.din[sym-1];
      else if (PAR == 1 && sym == 9) exp_b = e.par;
      else                          exp_b = 1'b1;
      if (tx_m !== exp_b) nerr++;
      if (done_m === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i + 1;
      end
      if (busy_m !== 1'b1) busy_low++;
      @(negedge clk);
    end
    check_val($sformatf("frame_bits_%02h", e.din), nerr, 0);
    check_val($sformatf("done_cycle_%02h", e.din), done_at, e.len);
    check_val($sformatf("done_count_%02h", e.din), done_cnt, 1);
    check_val($sformatf("busy_in_frame_%02h", e.din), busy_low, 0);
  endtask

  task automatic measure_gap(input string name);
    int g;
    g = 0;
    while (tx_m === 1'b1 && g < 50) begin
      g++;
      @(negedge clk);
    end
    check_val(name, g, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1, r2, txlow, bsy;
    vec_t v;

    vecs[0] = '{1'b0, 8'hA5, 1'b0, (10 + PAR) * CPB};
    vecs[1] = '{1'b0, 8'h07, 1'b1, (10 + PAR) * CPB};
    vecs[2] = '{1'b0, 8'h03, 1'b0, (10 + PAR) * CPB};
    vecs[3] = '{1'b0, 8'h80, 1'b1, (10 + PAR) * CPB};
    vecs[4] = '{1'b0, 8'hFF, 1'b0, (10 + PAR) * CPB};
    vecs[5] = '{1'b1, 8'h55, 1'b0, (11 + PAR) * CPB};
    vecs[6] = '{1'b1, 8'h0F, 1'b0, (11 + PAR) * CPB};

    rst_ = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_tx", int'(tx1), 1);
    check_val("rst_busy", int'(busy1), 0);
    check_val("rst_ren", int'(ren1), 0);
    check_val("rst_done", int'(done1), 0);
    rst_ = 1'b1;

    // FIFO left empty: nothing may happen
    r1 = ren_cnt1; txlow = 0; bsy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx1 !== 1'b1) txlow++;
      if (busy1 !== 1'b0) bsy++;
    end
    check_val("empty_ren", ren_cnt1 - r1, 0);
    check_val("empty_tx_low", txlow, 0);
    check_val("empty_busy", bsy, 0);

    for (int k = 0; k < 7; k++) begin
      r1 = ren_cnt1; r2 = ren_cnt2;
      push(vecs[k]);
      check_frame();
      repeat (3) @(negedge clk);
      check_val($sformatf("ren_pulses_%02h", vecs[k].din),
                vecs[k].sel ? (ren_cnt2 - r2) : (ren_cnt1 - r1), 1);
      check_val($sformatf("idle_busy_%02h", vecs[k].din), int'(busy_m), 0);
    end

    // back-to-back frames from a pre-filled FIFO
    sel = 1'b0;
    r1 = ren_cnt1;
    v = '{1'b0, 8'h01, 1'b1, (10 + PAR) * CPB}; push(v);
    v = '{1'b0, 8'hFF, 1'b0, (10 + PAR) * CPB}; push(v);
    v = '{1'b0, 8'h00, 1'b0, (10 + PAR) * CPB}; push(v);
    check_frame();
    measure_gap("gap_1_2");
    check_frame();
    measure_gap("gap_2_3");
    check_frame();
    repeat (5) @(negedge clk);
    check_val("burst_ren_pulses", ren_cnt1 - r1, 3);
    check_val("burst_busy_end", int'(busy1), 0);
    check_val("burst_empty_end", int'(empty1), 1);

    // reset in the middle of the data bits of 0xC3
    @(posedge clk);
    #2 fq1.push_back(8'hC3);
    txlow = 0;
    while (tx1 !== 1'b0 && txlow < 300) begin
      @(negedge clk);
      txlow++;
    end
    check_val("c3_started", int'(tx1), 0);
    repeat (10) @(negedge clk);
    check_val("c3_mid_busy", int'(busy1), 1);
    rst_ = 1'b0;
    #1;
    check_val("abort_tx", int'(tx1), 1);
    check_val("abort_busy", int'(busy1), 0);
    check_val("abort_ren", int'(ren1), 0);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    r1 = ren_cnt1; txlow = 0; bsy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx1 !== 1'b1) txlow++;
      if (busy1 !== 1'b0) bsy++;
    end
    check_val("post_abort_tx_low", txlow, 0);
    check_val("post_abort_busy", bsy, 0);
    check_val("post_abort_ren", ren_cnt1 - r1, 0);
    check_val("sb_leftover", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
